// File: rtl/bb_core_seq.sv
// Grid of N_WG x N_AG dot-product tiles with 2/4/8-bit operands, a two-stage
// multiply/reduce pipeline, per-tile accumulation and a serial valid/ready drain.
module bb_core_seq #(
  parameter int N_WG   = 4,
  parameter int N_AG   = 4,
  parameter int LANES  = 16,
  parameter int ACT_W  = 8,
  parameter int WGT_W  = 8,
  parameter int N_BIAS = 16,
  parameter int PSUM_W = 24,
  localparam int N_T   = N_WG * N_AG,
  localparam int IDX_W = (N_T > 1) ? $clog2(N_T) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [ACT_W*LANES*N_AG-1:0]   i_Act,
  input  logic [WGT_W*LANES*N_WG-1:0]   i_Weight,
  input  logic [1:0]                    i_Precision,
  input  logic [1:0]                    w_Precision,
  input  logic [N_BIAS*N_T-1:0]         i_Bias,
  input  logic                          i_Sel_Bias,
  input  logic                          i_Flush,
  input  logic                          i_Valid,
  input  logic                          i_Last,
  output logic                          o_Ready,
  output logic                          o_Psum_Valid,
  input  logic                          i_Psum_Ready,
  output logic [PSUM_W-1:0]             o_Psum,
  output logic [IDX_W-1:0]              o_Psum_Idx,
  output logic                          o_Done
);

  // state  | meaning
  // IDLE   | waiting for the first beat of a pass
  // ACCUM  | accepting beats, accumulating per tile
  // FINISH | pipeline emptying, inputs blocked
  // DRAIN  | presenting tile results k = 0..N_T-1
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_DRAIN} state_e;

  // unsigned 8b act x signed 8b weight fits in 17 signed bits
  localparam int PROD_W = 17;

  state_e                     state_q;
  logic                       s1_vld_q;
  logic [1:0]                 fin_cnt_q;
  logic                       psum_vld_q;
  logic                       done_q;
  logic [IDX_W-1:0]           idx_q;
  logic signed [PROD_W-1:0]   prod_d [N_T][LANES];
  logic signed [PROD_W-1:0]   prod_q [N_T][LANES];
  logic signed [PSUM_W-1:0]   acc_d  [N_T];
  logic signed [PSUM_W-1:0]   bias_d [N_T];
  logic signed [PSUM_W-1:0]   acc_q  [N_T];
  logic signed [PSUM_W-1:0]   buf_q  [N_T];
  logic                       accept;

  function automatic logic signed [8:0] act_dec(input logic [7:0] f, input logic [1:0] p);
    case (p)
      2'b00:   act_dec = {7'd0, f[1:0]};
      2'b01:   act_dec = {5'd0, f[3:0]};
      default: act_dec = {1'b0, f};
    endcase
  endfunction

  function automatic logic signed [7:0] wgt_dec(input logic [7:0] f, input logic [1:0] p);
    case (p)
      2'b00:   wgt_dec = {{6{f[1]}}, f[1:0]};
      2'b01:   wgt_dec = {{4{f[3]}}, f[3:0]};
      default: wgt_dec = f;
    endcase
  endfunction

  assign o_Ready      = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign accept       = i_Valid && o_Ready;
  assign o_Psum_Valid = psum_vld_q;
  assign o_Psum       = buf_q[idx_q];
  assign o_Psum_Idx   = idx_q;
  assign o_Done       = done_q;

  // tile t = N_AG*w + a pairs weight group w with activation group a
  always_comb begin
    for (int t = 0; t < N_T; t++) begin
      for (int l = 0; l < LANES; l++) begin
        prod_d[t][l] = PROD_W'(act_dec(i_Act[((t % N_AG)*LANES + l)*ACT_W +: 8], i_Precision))
                     * PROD_W'(wgt_dec(i_Weight[((t / N_AG)*LANES + l)*WGT_W +: 8], w_Precision));
      end
    end
  end

  always_comb begin
    for (int t = 0; t < N_T; t++) begin
      acc_d[t] = acc_q[t];
      for (int l = 0; l < LANES; l++) begin
        acc_d[t] = acc_d[t] + PSUM_W'(prod_q[t][l]);
      end
      bias_d[t] = i_Sel_Bias ? PSUM_W'(signed'(i_Bias[t*N_BIAS +: N_BIAS])) : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || i_Flush) begin
      state_q    <= S_IDLE;
      s1_vld_q   <= 1'b0;
      fin_cnt_q  <= '0;
      psum_vld_q <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      for (int t = 0; t < N_T; t++) acc_q[t] <= '0;
      if (RST) begin
        for (int t = 0; t < N_T; t++) buf_q[t] <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      s1_vld_q <= accept;
      if (accept) prod_q <= prod_d;
      if (s1_vld_q) acc_q <= acc_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc_q     <= bias_d;
            fin_cnt_q <= 2'd1;
            state_q   <= i_Last ? S_FINISH : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept && i_Last) begin
            fin_cnt_q <= 2'd1;
            state_q   <= S_FINISH;
          end
        end
        S_FINISH: begin
          // the last beat has reached the accumulators once the count expires
          if (fin_cnt_q == 2'd0) begin
            buf_q      <= acc_q;
            idx_q      <= '0;
            psum_vld_q <= 1'b1;
            state_q    <= S_DRAIN;
          end else begin
            fin_cnt_q <= fin_cnt_q - 2'd1;
          end
        end
        S_DRAIN: begin
          if (psum_vld_q && i_Psum_Ready) begin
            if (idx_q == IDX_W'(N_T - 1)) begin
              psum_vld_q <= 1'b0;
              done_q     <= 1'b1;
              idx_q      <= '0;
              state_q    <= S_IDLE;
              for (int t = 0; t < N_T; t++) acc_q[t] <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bb_core_seq.sv
// Bench for bb_core_seq: directed passes plus random passes scored against an
// arithmetic model of the tile dot products.
module tb_bb_core_seq;
  localparam int N_T = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [511:0]  i_Act, i_Weight;
  logic [1:0]    i_Precision, w_Precision;
  logic [255:0]  i_Bias;
  logic          i_Sel_Bias, i_Flush, i_Valid, i_Last, i_Psum_Ready;
  logic          o_Ready, o_Psum_Valid, o_Done;
  logic [23:0]   o_Psum;
  logic [3:0]    o_Psum_Idx;

  bb_core_seq dut (
    .CLK(CLK), .RST(RST), .i_Act(i_Act), .i_Weight(i_Weight),
    .i_Precision(i_Precision), .w_Precision(w_Precision), .i_Bias(i_Bias),
    .i_Sel_Bias(i_Sel_Bias), .i_Flush(i_Flush), .i_Valid(i_Valid), .i_Last(i_Last),
    .o_Ready(o_Ready), .o_Psum_Valid(o_Psum_Valid), .i_Psum_Ready(i_Psum_Ready),
    .o_Psum(o_Psum), .o_Psum_Idx(o_Psum_Idx), .o_Done(o_Done)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;

  logic [511:0] b_act[$], b_wgt[$];
  logic [1:0]   b_ip[$], b_wp[$];

  logic [3:0]   hs_idx [64];
  logic [23:0]  hs_psum[64];
  int hs_n, first_vld, done_cnt, done_cyc, last_hs_cyc, stall_bad, ready_bad, drop_cnt;
  bit timed_out, stopped;
  bit [3:0] rp;

  function automatic longint act_val(input logic [7:0] f, input logic [1:0] p);
    int n = (p == 2'b00) ? 2 : (p == 2'b01) ? 4 : 8;
    return longint'(f) % (longint'(1) << n);
  endfunction

  function automatic longint wgt_val(input logic [7:0] f, input logic [1:0] p);
    int n = (p == 2'b00) ? 2 : (p == 2'b01) ? 4 : 8;
    longint v = longint'(f) % (longint'(1) << n);
    if (v >= (longint'(1) << (n - 1))) v -= (longint'(1) << n);
    return v;
  endfunction

  function automatic logic [23:0] model_psum(input int k, input bit sel, input logic [255:0] bias);
    longint s;
    logic [511:0] va, vw;
    logic [15:0] bk;
    int w = k / 4, a = k % 4;
    bk = bias[k*16 +: 16];
    s = sel ? longint'($signed(bk)) : 0;
    for (int b = 0; b < b_act.size(); b++) begin
      va = b_act[b]; vw = b_wgt[b];
      for (int l = 0; l < 16; l++)
        s += act_val(va[(a*16 + l)*8 +: 8], b_ip[b]) * wgt_val(vw[(w*16 + l)*8 +: 8], b_wp[b]);
    end
    return s[23:0];
  endfunction

  task automatic const_beats(input int n, input logic [7:0] av, input logic [7:0] wv, input logic [1:0] p);
    b_act.delete(); b_wgt.delete(); b_ip.delete(); b_wp.delete();
    for (int b = 0; b < n; b++) begin
      b_act.push_back({64{av}}); b_wgt.push_back({64{wv}});
      b_ip.push_back(p); b_wp.push_back(p);
    end
  endtask

  task automatic rand_beats(input int n);
    logic [511:0] va, vw;
    b_act.delete(); b_wgt.delete(); b_ip.delete(); b_wp.delete();
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < 16; j++) begin
        va[j*32 +: 32] = $urandom(); vw[j*32 +: 32] = $urandom();
      end
      b_act.push_back(va); b_wgt.push_back(vw);
      b_ip.push_back(2'($urandom_range(0, 3))); b_wp.push_back(2'($urandom_range(0, 3)));
    end
  endtask

  task automatic send_beats(input bit sel, input logic [255:0] bias, input bit last);
    drop_cnt = 0;
    for (int b = 0; b < b_act.size(); b++) begin
      @(negedge CLK);
      if (!o_Ready) drop_cnt++;
      i_Valid = 1'b1; i_Act = b_act[b]; i_Weight = b_wgt[b];
      i_Precision = b_ip[b]; w_Precision = b_wp[b];
      i_Sel_Bias = sel; i_Bias = bias;
      i_Last = last && (b == b_act.size() - 1);
    end
  endtask

  // Observes the drain at each negedge; cycle 1 is the cycle after the last beat.
  task automatic collect(input int stop_idx);
    bit prev_stall = 1'b0;
    logic [3:0] p_idx = '0;
    logic [23:0] p_ps = '0;
    hs_n = 0; first_vld = -1; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    stall_bad = 0; ready_bad = 0; timed_out = 1'b0; stopped = 1'b0;
    for (int i = 0; i < 64; i++) begin hs_idx[i] = 'x; hs_psum[i] = 'x; end
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge CLK);
      i_Valid = 1'b0; i_Last = 1'b0; i_Sel_Bias = 1'b0;
      if (prev_stall && (!o_Psum_Valid || o_Psum_Idx !== p_idx || o_Psum !== p_ps)) stall_bad++;
      if (o_Psum_Valid && first_vld < 0) first_vld = cyc;
      if (o_Done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (o_Ready && done_cyc < 0) ready_bad++;
      if (done_cyc >= 0 && cyc > done_cyc) return;
      if (o_Psum_Valid && int'(o_Psum_Idx) == stop_idx) begin stopped = 1'b1; return; end
      i_Psum_Ready = rp[cyc % 4];
      prev_stall = o_Psum_Valid && !i_Psum_Ready;
      p_idx = o_Psum_Idx; p_ps = o_Psum;
      if (o_Psum_Valid && i_Psum_Ready) begin
        if (hs_n < 64) begin hs_idx[hs_n] = o_Psum_Idx; hs_psum[hs_n] = o_Psum; end
        hs_n++; last_hs_cyc = cyc;
      end
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_chk++; if (o_Ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", o_Ready); else n_pass++;
    n_chk++; if (o_Psum_Valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_Psum_Valid); else n_pass++;
    n_chk++; if (o_Psum !== 24'd0) $display("FAIL reset_psum got %0h exp 0", o_Psum); else n_pass++;
    n_chk++; if (o_Psum_Idx !== 4'd0) $display("FAIL reset_idx got %0d exp 0", o_Psum_Idx); else n_pass++;
    n_chk++; if (o_Done !== 1'b0) $display("FAIL reset_done got %b exp 0", o_Done); else n_pass++;
    RST = 1'b0;
  endtask

  task automatic test_8b_single();
    const_beats(1, 8'h01, 8'hFF, 2'b10);
    rp = 4'b1111;
    send_beats(1'b0, '0, 1'b1);
    collect(-1);
    n_chk++; if (timed_out || hs_n !== 16) $display("FAIL 8b_count got %0d exp 16 (timeout %b)", hs_n, timed_out); else n_pass++;
    n_chk++; if (first_vld !== 3) $display("FAIL 8b_latency got %0d exp 3", first_vld); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (hs_idx[k] !== 4'(k) || hs_psum[k] !== 24'(-16))
        $display("FAIL 8b_psum[%0d] got idx %0d val %0d exp idx %0d val -16", k, hs_idx[k], $signed(hs_psum[k]), k);
      else n_pass++;
    end
    n_chk++; if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1)
      $display("FAIL 8b_done got cnt %0d cyc %0d exp cnt 1 cyc %0d", done_cnt, done_cyc, last_hs_cyc + 1); else n_pass++;
    n_chk++; if (drop_cnt !== 0) $display("FAIL 8b_beat_ready got %0d not-ready beats exp 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_2b_multi();
    const_beats(4, 8'hFF, 8'hFE, 2'b00);
    rp = 4'b1111;
    send_beats(1'b0, '0, 1'b1);
    collect(-1);
    n_chk++; if (timed_out || hs_n !== 16) $display("FAIL 2b_count got %0d exp 16", hs_n); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (hs_idx[k] !== 4'(k) || hs_psum[k] !== 24'(-384))
        $display("FAIL 2b_psum[%0d] got idx %0d val %0d exp val -384", k, hs_idx[k], $signed(hs_psum[k]));
      else n_pass++;
    end
    n_chk++; if (ready_bad !== 0) $display("FAIL 2b_ready_low got %0d high cycles exp 0", ready_bad); else n_pass++;
    n_chk++; if (done_cnt !== 1) $display("FAIL 2b_done got %0d exp 1", done_cnt); else n_pass++;
  endtask

  task automatic test_bias();
    logic [255:0] bias;
    for (int k = 0; k < 16; k++) bias[k*16 +: 16] = 16'(k);
    for (int s = 1; s >= 0; s--) begin
      const_beats(1, 8'h00, 8'($urandom()), 2'b10);
      rp = 4'b1111;
      send_beats(s[0], bias, 1'b1);
      collect(-1);
      n_chk++; if (timed_out || hs_n !== 16) $display("FAIL bias%0d_count got %0d exp 16", s, hs_n); else n_pass++;
      for (int k = 0; k < 16; k++) begin
        n_chk++;
        if (hs_psum[k] !== (s ? 24'(k) : 24'd0))
          $display("FAIL bias%0d_psum[%0d] got %0d exp %0d", s, k, $signed(hs_psum[k]), s ? k : 0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] bias;
    for (int j = 0; j < 8; j++) bias[j*32 +: 32] = $urandom();
    rand_beats(2);
    rp = 4'b1001;
    send_beats(1'b1, bias, 1'b1);
    collect(-1);
    n_chk++; if (timed_out || hs_n !== 16) $display("FAIL bp_count got %0d exp 16", hs_n); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (hs_idx[k] !== 4'(k) || hs_psum[k] !== model_psum(k, 1'b1, bias))
        $display("FAIL bp_psum[%0d] got idx %0d val %0h exp idx %0d val %0h", k, hs_idx[k], hs_psum[k], k, model_psum(k, 1'b1, bias));
      else n_pass++;
    end
    n_chk++; if (stall_bad !== 0) $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_bad); else n_pass++;
    n_chk++; if (done_cnt !== 1) $display("FAIL bp_done got %0d exp 1", done_cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    const_beats(17, 8'hFF, 8'h80, 2'b10);
    rp = 4'b1111;
    send_beats(1'b0, '0, 1'b1);
    collect(-1);
    n_chk++; if (timed_out || hs_n !== 16) $display("FAIL wrap_count got %0d exp 16", hs_n); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (hs_psum[k] !== 24'd7899136) $display("FAIL wrap_psum[%0d] got %0d exp 7899136", k, hs_psum[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [255:0] bias;
    bit sel;
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 8; j++) bias[j*32 +: 32] = $urandom();
      sel = 1'($urandom());
      rand_beats($urandom_range(1, 5));
      rp = 4'($urandom()) | 4'b0010;
      send_beats(sel, bias, 1'b1);
      collect(-1);
      n_chk++; if (timed_out || hs_n !== 16 || done_cnt !== 1 || stall_bad !== 0)
        $display("FAIL rand%0d_proto got hs %0d done %0d stall %0d exp 16 1 0", p, hs_n, done_cnt, stall_bad); else n_pass++;
      for (int k = 0; k < 16; k++) begin
        n_chk++;
        if (hs_idx[k] !== 4'(k) || hs_psum[k] !== model_psum(k, sel, bias))
          $display("FAIL rand%0d_psum[%0d] got idx %0d val %0h exp val %0h", p, k, hs_idx[k], hs_psum[k], model_psum(k, sel, bias));
        else n_pass++;
      end
    end
  endtask

  task automatic check_ones_pass(input string tag);
    int dones = 0;
    for (int c = 0; c < 6; c++) begin @(negedge CLK); if (o_Done) dones++; end
    n_chk++; if (dones !== 0) $display("FAIL %s_no_done got %0d pulses exp 0", tag, dones); else n_pass++;
    const_beats(1, 8'h01, 8'h01, 2'b10);
    rp = 4'b1111;
    send_beats(1'b0, '0, 1'b1);
    collect(-1);
    n_chk++; if (timed_out || hs_n !== 16) $display("FAIL %s_after_count got %0d exp 16", tag, hs_n); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_chk++;
      if (hs_psum[k] !== 24'd16) $display("FAIL %s_after_psum[%0d] got %0d exp 16", tag, k, $signed(hs_psum[k]));
      else n_pass++;
    end
  endtask

  task automatic test_flush_accum();
    rand_beats(3);
    send_beats(1'b1, {8{$urandom()}}, 1'b0);
    @(negedge CLK);
    i_Flush = 1'b1; i_Valid = 1'b1; i_Last = 1'b1; i_Act = {16{$urandom()}}; i_Weight = {16{$urandom()}};
    @(negedge CLK);
    i_Flush = 1'b0; i_Valid = 1'b0; i_Last = 1'b0;
    n_chk++; if (o_Psum_Valid !== 1'b0 || o_Ready !== 1'b1 || o_Done !== 1'b0)
      $display("FAIL flacc_state got valid %b ready %b done %b exp 0 1 0", o_Psum_Valid, o_Ready, o_Done); else n_pass++;
    check_ones_pass("flacc");
  endtask

  task automatic test_flush_drain();
    rand_beats(1);
    rp = 4'b1111;
    send_beats(1'b0, '0, 1'b1);
    collect(5);
    n_chk++; if (!stopped || hs_n !== 5 || hs_idx[4] !== 4'd4)
      $display("FAIL fldr_reach got stopped %b hs %0d exp 1 5", stopped, hs_n); else n_pass++;
    i_Flush = 1'b1; i_Psum_Ready = 1'b1;
    @(negedge CLK);
    i_Flush = 1'b0;
    n_chk++; if (o_Psum_Valid !== 1'b0 || o_Done !== 1'b0 || o_Ready !== 1'b1)
      $display("FAIL fldr_state got valid %b done %b ready %b exp 0 0 1", o_Psum_Valid, o_Done, o_Ready); else n_pass++;
    check_ones_pass("fldr");
  endtask

  task automatic test_rst_drain();
    rand_beats(2);
    rp = 4'b1111;
    send_beats(1'b0, '0, 1'b1);
    collect(7);
    n_chk++; if (!stopped) $display("FAIL rstdr_reach got stopped %b exp 1", stopped); else n_pass++;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_chk++; if (o_Ready !== 1'b1 || o_Psum_Valid !== 1'b0 || o_Psum !== 24'd0 || o_Psum_Idx !== 4'd0 || o_Done !== 1'b0)
      $display("FAIL rstdr_outputs got ready %b valid %b psum %0h idx %0d done %b exp 1 0 0 0 0",
               o_Ready, o_Psum_Valid, o_Psum, o_Psum_Idx, o_Done); else n_pass++;
    check_ones_pass("rstdr");
  endtask

  initial begin
    RST = 1'b1; i_Flush = 1'b0; i_Valid = 1'b0; i_Last = 1'b0; i_Sel_Bias = 1'b0;
    i_Act = '0; i_Weight = '0; i_Bias = '0; i_Precision = 2'b10; w_Precision = 2'b10;
    i_Psum_Ready = 1'b1; rp = 4'b1111;
    test_reset();
    test_8b_single();
    test_2b_multi();
    test_bias();
    test_backpressure();
    test_wrap();
    test_random();
    test_flush_accum();
    test_flush_drain();
    test_rst_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/bb_core_seq.md
Name: bb_core_seq

Overview:
- Parametrised successor of the fixed 4x4 BitBlade core.
- Holds an N_WG x N_AG grid of dot-product tiles. Each tile multiplies one activation group by one weight group over LANES lanes at a selectable 2/4/8-bit precision and accumulates across beats.
- On the last beat it adds no further operands, snapshots every tile result, and drains the results serially over a valid/ready port.
- Sits between the activation/weight buffers and the output-requantisation stage.

Parameters:
- N_WG, 4, number of weight groups (tile rows).
- N_AG, 4, number of activation groups (tile columns).
- LANES, 16, elements per group per beat.
- ACT_W, 8, bits per activation lane field.
- WGT_W, 8, bits per weight lane field.
- N_BIAS, 16, bias width per tile.
- PSUM_W, 24, accumulator and output width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- i_Act  in  ACT_W*LANES*N_AG  activation groups; group a at slice a.
- i_Weight  in  WGT_W*LANES*N_WG  weight groups; group w at slice w.
- i_Precision  in  2  activation precision: 00=2b, 01=4b, 1x=8b.
- w_Precision  in  2  weight precision, same encoding.
- i_Bias  in  N_BIAS*N_WG*N_AG  signed bias; tile k=N_AG*w+a at slice k.
- i_Sel_Bias  in  1  on first beat of a pass: seed accumulators with bias.
- i_Flush  in  1  abort and clear.
- i_Valid  in  1  input beat valid.
- i_Last  in  1  qualifies final beat of a pass.
- o_Ready  out  1  core accepts a beat.
- o_Psum_Valid  out  1  o_Psum/o_Psum_Idx valid.
- i_Psum_Ready  in  1  downstream accepts psum.
- o_Psum  out  PSUM_W  signed tile result.
- o_Psum_Idx  out  clog2(N_WG*N_AG)  tile index k.
- o_Done  out  1  one-cycle pulse after final psum handshake.

Behaviour:
- Reset:
  - state=IDLE, accumulators=0, pipeline valids=0.
  - o_Ready=1, o_Psum_Valid=0, o_Psum=0, o_Psum_Idx=0, o_Done=0.
- Operand decode:
  - Precision n=2/4/8 uses the low n bits of each lane field.
  - Activation is unsigned (zero-extended). Weight is signed (sign-extended).
  - Precision is sampled per beat.
- Handshake: a beat is accepted when i_Valid & o_Ready.
- FSM:
  - IDLE: an accepted beat goes to ACCUM. That first beat seeds each accumulator with sign-extended bias if i_Sel_Bias=1, else 0.
  - ACCUM: subsequent beats add to the accumulators. An accepted beat with i_Last=1 goes to FINISH.
  - FINISH: o_Ready=0 for 2 cycles while the pipeline empties, then snapshot all accumulators into the drain buffer and go to DRAIN.
  - DRAIN: o_Ready=0. Present k=0..N_WG*N_AG-1 in order, one per handshake. After k=last handshakes: o_Done=1 for one cycle, accumulators cleared, go to IDLE.
  - An accepted first beat with i_Last=1 goes directly to FINISH.
- Pipeline and latency:
  - Stage 1 registers per-lane products.
  - Stage 2 reduces them with an adder tree and adds to the accumulator.
  - A beat accepted at cycle t is reflected in the accumulator at t+2.
  - The last beat at t gives o_Psum_Valid=1 at t+3.
- Arithmetic: full-width products, wrap-around modulo 2^PSUM_W. No saturation.
- Backpressure: while o_Psum_Valid & !i_Psum_Ready, o_Psum and o_Psum_Idx hold stable.
- i_Flush:
  - Next cycle: state=IDLE, accumulators=0, pipeline valids=0, o_Psum_Valid=0.
  - No o_Done is produced. A beat presented in the flush cycle is dropped.
  - Flush has priority over all other events.
- RST: same effect as i_Flush and also restores all reset values. RST overrides flush.
- i_Valid while o_Ready=0 is ignored. i_Last without i_Valid is ignored.

Test Plan:
- 8b/8b, all act=1, weight=0xFF (-1), one beat with i_Last -> 16 psums of -16, idx 0..15 in order, o_Psum_Valid first at t+3, o_Done pulse after idx 15.
- 2b/2b, act fields 0xFF (->3), weight 0xFE (->-2), 4 beats -> every psum = -384; o_Ready low from the cycle after last until o_Done.
- i_Sel_Bias=1, bias tile k = k, act=0, one beat -> psum k = k. Repeat with i_Sel_Bias=0 -> all 0.
- i_Psum_Ready toggling 1,0,0,1 during drain -> no index skipped or repeated, outputs stable while stalled, o_Done exactly once.
- 8b, act=255, weight=0x80 (-128), 17 beats -> psum = 7899136 (wrapped from -8878080).
- i_Flush mid-ACCUM, and separately mid-DRAIN at idx 5 -> o_Psum_Valid=0 next cycle, no o_Done. Following 1-beat pass (act=1, weight=1) -> all psums 16. RST mid-DRAIN -> all outputs at reset values next cycle.
